std_sync_fifo: RTL and testbench



---
 rtl/std_fifo_pkg.sv | 22 ++
 rtl/std_sync_fifo_if.sv | 29 ++
 rtl/std_fifo_ram.sv | 32 +++
 rtl/std_sync_fifo.sv | 83 ++++++++
 tb/tb_std_sync_fifo.sv | 135 +++++++++++++
 5 files changed

// File: rtl/std_fifo_pkg.sv
// Shared constants and helpers for the std_sync_fifo family.
package std_fifo_pkg;

  localparam int unsigned STD_FIFO_DEF_AF_MARGIN = 4;
  localparam int unsigned STD_FIFO_DEF_AE_MARGIN = 2;

  // Accepted operations in a cycle, encoded as {push_ok, pop_ok}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/std_sync_fifo_if.sv
// Push/pop handshake, data and occupancy flags of std_sync_fifo.
interface std_sync_fifo_if import std_fifo_pkg::*; #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32
) ();

  localparam int unsigned CW = clog2(DEPTH) + 1;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             almost_empty;
  logic             almost_full;

  modport master (
    output push, pop, d,
    input  q, full, empty, count, almost_empty, almost_full
  );

  modport slave (
    input  push, pop, d,
    output q, full, empty, count, almost_empty, almost_full
  );

endinterface

// File: rtl/std_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port (old data on collision).
module std_fifo_ram import std_fifo_pkg::*; #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  localparam int unsigned AW   = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Array left unreset so it maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/std_sync_fifo.sv
// Single-clock FIFO with registered read data and count-derived flags.
// Optional STD_FIFO_CHECK_EN adds simulation-only overflow/underflow messages.
module std_sync_fifo import std_fifo_pkg::*; #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned AF_MARGIN = STD_FIFO_DEF_AF_MARGIN,
  parameter int unsigned AE_MARGIN = STD_FIFO_DEF_AE_MARGIN
) (
  input  logic             rst,
  input  logic             clk,
  std_sync_fifo_if.slave   bus
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_push_ok;
  logic             w_pop_ok;
  fifo_op_e         w_op;
  logic [WIDTH-1:0] w_rdata;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop_ok  = bus.pop && !w_empty;
  // A pop frees the slot in the same cycle, so push is allowed while full.
  assign w_push_ok = bus.push && (!w_full || w_pop_ok);
  assign w_op      = fifo_op_e'({w_push_ok, w_pop_ok});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case (w_op)
        OP_PUSH: r_count <= r_count + 1'b1;
        OP_POP:  r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  std_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_push_ok),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.d),
    .i_re    (w_pop_ok),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  assign bus.q            = w_rdata;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.count        = r_count;
  assign bus.almost_empty = (r_count <= CW'(AE_MARGIN));
  assign bus.almost_full  = (r_count >= CW'(DEPTH - AF_MARGIN));

`ifdef STD_FIFO_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      if (bus.push && w_full && !bus.pop)
        $display("ERROR %m @%0t: push while full (overflow)", $time);
      if (bus.pop && w_empty)
        $display("ERROR %m @%0t: pop while empty (underflow)", $time);
    end
  end
`else
`endif

endmodule

// File: tb/tb_std_sync_fifo.sv
// Directed plus random bench for std_sync_fifo against a queue-based reference model.
module tb_std_sync_fifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AF    = 1;
  localparam int unsigned AE    = 2;

  logic clk;
  logic rst;

  std_sync_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  std_sync_fifo #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AF_MARGIN (AF),
    .AE_MARGIN (AE)
  ) dut (
    .rst (rst),
    .clk (clk),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks;
  int unsigned n_fail;
  logic [WIDTH-1:0] model [$];
  logic [WIDTH-1:0] exp_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int unsigned n;
    n = model.size();
    check({tag, ".count"}, 32'(bus.count), n);
    check({tag, ".empty"}, 32'(bus.empty), 32'(n == 0));
    check({tag, ".full"},  32'(bus.full),  32'(n == DEPTH));
    check({tag, ".aempty"}, 32'(bus.almost_empty), 32'(n <= AE));
    check({tag, ".afull"}, 32'(bus.almost_full), 32'(n >= DEPTH - AF));
    check({tag, ".q"},     32'(bus.q), 32'(exp_q));
  endtask

  task automatic step(input string tag, input logic p, input logic o, input logic [WIDTH-1:0] data);
    bit pop_ok, push_ok;
    bus.push = p;
    bus.pop  = o;
    bus.d    = data;
    @(posedge clk);
    pop_ok  = o && (model.size() > 0);
    push_ok = p && ((model.size() < DEPTH) || pop_ok);
    if (pop_ok)  exp_q = model.pop_front();
    if (push_ok) model.push_back(data);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    model.delete();
    exp_q = '0;
    check_all(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_q    = '0;
    rst      = 1'b0;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.d    = '0;
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk);
    rst = 1'b1;
    step("idle", 1'b0, 1'b0, 8'h00);

    // Fill to full, then an ignored fifth push.
    step("fill0", 1'b1, 1'b0, 8'hA1);
    step("fill1", 1'b1, 1'b0, 8'hB2);
    step("fill2", 1'b1, 1'b0, 8'hC3);
    step("fill3", 1'b1, 1'b0, 8'hD4);
    step("ovf",   1'b1, 1'b0, 8'hE5);

    // Drain, then an extra pop must leave q holding D4.
    for (int i = 0; i < 4; i++) step("drain", 1'b0, 1'b1, 8'h00);
    step("unf",  1'b0, 1'b1, 8'h00);
    check("q_hold_D4", 32'(bus.q), 32'h0000_00D4);
    step("unf_push", 1'b1, 1'b1, 8'h66);
    step("pop66", 1'b0, 1'b1, 8'h00);

    // Steady push+pop at count 2 across pointer wrap.
    step("pre0", 1'b1, 1'b0, 8'h10);
    step("pre1", 1'b1, 1'b0, 8'h11);
    for (int i = 0; i < 10; i++) step("pp2", 1'b1, 1'b1, 8'(8'h20 + i));

    // Push+pop while full.
    step("tofull0", 1'b1, 1'b0, 8'h30);
    step("tofull1", 1'b1, 1'b0, 8'h31);
    step("fullpp", 1'b1, 1'b1, 8'h55);
    for (int i = 0; i < 4; i++) step("drain55", 1'b0, 1'b1, 8'h00);
    check("q_last_55", 32'(bus.q), 32'h0000_0055);

    // Asynchronous reset mid-stream at count 3.
    for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 1'b0, 8'(8'h40 + i));
    do_reset("midrst");
    step("push77", 1'b1, 1'b0, 8'h77);
    step("pop77",  1'b0, 1'b1, 8'h00);
    check("q_77", 32'(bus.q), 32'h0000_0077);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
      else step("rnd", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
                8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
